// File: rtl/nasti_stream_rr_arbiter.sv
// ----------------------------------------------------------------------------
// nasti_stream_rr_arbiter
//
// Packet-level round-robin arbiter for an N:1 NASTI-stream mux. Picks one
// input whose t_dest matches DEST_ID, holds the grant until t_last (or until
// the locked port has been silent for TIMEOUT cycles), then gives priority to
// the port after the one just served. Every release inserts one idle cycle
// before the next grant.
//
// Ports
//   aclk, aresetn   clock (rising edge), asynchronous active-low reset
//   in_valid        t_valid of each input port            [N_PORT]
//   in_last         t_last of each input port             [N_PORT]
//   in_dest         t_dest, port i at [i*DEST_WIDTH +: DEST_WIDTH]
//   in_ready        t_ready back to each input port       [N_PORT]
//   out_ready       t_ready from the downstream slave
//   out_valid       t_valid to the downstream slave
//   sel             mux select for the payload fields
//   sel_en          high while a port holds the grant
//   pkt_done        one-cycle pulse, packet finished with t_last
//   pkt_port        port of the last finished or timed-out packet
//   pkt_beats       beat count of that packet (saturating)
//   timeout_err     one-cycle pulse, grant released by the idle timeout
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no grant; arbitrate among eligible ports, lock the winner
// S_LOCK | winner owns the output until its t_last beat or a timeout
// ----------------------------------------------------------------------------
module nasti_stream_rr_arbiter #(
    parameter int N_PORT     = 4,
    parameter int DEST_WIDTH = 2,
    parameter int DEST_ID    = 0,
    parameter int TIMEOUT    = 64,
    parameter int BEAT_W     = 16,
    parameter int SEL_W      = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_PORT-1:0]            in_valid,
    input  logic [N_PORT-1:0]            in_last,
    input  logic [N_PORT*DEST_WIDTH-1:0] in_dest,
    output logic [N_PORT-1:0]            in_ready,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [SEL_W-1:0]             sel,
    output logic                         sel_en,
    output logic                         pkt_done,
    output logic [SEL_W-1:0]             pkt_port,
    output logic [BEAT_W-1:0]            pkt_beats,
    output logic                         timeout_err
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [SEL_W-1:0]    sel_q, sel_nxt;
    logic [SEL_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [SEL_W-1:0]    pkt_port_q, pkt_port_nxt;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [BEAT_W-1:0]   pkt_beats_q, pkt_beats_nxt;
    logic [BEAT_W-1:0]   beat_cnt_inc;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_nxt;
    logic                pkt_done_q, pkt_done_nxt;
    logic                timeout_err_q, timeout_err_nxt;

    logic [N_PORT-1:0]   elig;
    logic                found;
    logic [SEL_W-1:0]    winner;
    logic                sel_valid;
    logic                sel_last;
    logic                beat;

    // Eligibility and a two-pass round-robin scan: ports above rr_ptr first,
    // then wrap around to ports 0..rr_ptr.
    always_comb begin
        elig   = '0;
        found  = 1'b0;
        winner = '0;
        for (int j = 0; j < N_PORT; j++) begin
            elig[j] = in_valid[j] &&
                      (in_dest[j*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(DEST_ID));
        end
        for (int j = 0; j < N_PORT; j++) begin
            if (!found && elig[j] && (SEL_W'(j) > rr_ptr)) begin
                found  = 1'b1;
                winner = SEL_W'(j);
            end
        end
        for (int j = 0; j < N_PORT; j++) begin
            if (!found && elig[j] && (SEL_W'(j) <= rr_ptr)) begin
                found  = 1'b1;
                winner = SEL_W'(j);
            end
        end
    end

    // Locked-port view; decoded by compare so it is safe for any N_PORT.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        in_ready  = '0;
        for (int j = 0; j < N_PORT; j++) begin
            if (SEL_W'(j) == sel_q) begin
                sel_valid   = in_valid[j];
                sel_last    = in_last[j];
                in_ready[j] = (state == S_LOCK) && out_ready;
            end
        end
    end

    assign beat         = (state == S_LOCK) && sel_valid && out_ready;
    assign beat_cnt_inc = (beat_cnt == {BEAT_W{1'b1}}) ? beat_cnt : beat_cnt + 1'b1;

    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel_q;
        rr_ptr_nxt      = rr_ptr;
        pkt_port_nxt    = pkt_port_q;
        pkt_beats_nxt   = pkt_beats_q;
        beat_cnt_nxt    = beat_cnt;
        idle_cnt_nxt    = idle_cnt;
        pkt_done_nxt    = 1'b0;
        timeout_err_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                idle_cnt_nxt = '0;
                if (found) begin
                    sel_nxt   = winner;
                    state_nxt = S_LOCK;
                end
            end

            S_LOCK: begin
                if (beat) begin
                    if (sel_last) begin
                        pkt_done_nxt  = 1'b1;
                        pkt_port_nxt  = sel_q;
                        pkt_beats_nxt = beat_cnt_inc;
                        rr_ptr_nxt    = sel_q;
                        beat_cnt_nxt  = '0;
                        state_nxt     = S_IDLE;
                    end else begin
                        beat_cnt_nxt  = beat_cnt_inc;
                    end
                end

                // A beat needs sel_valid, so it never coincides with a timeout.
                if (TIMEOUT > 0) begin
                    if (sel_valid) begin
                        idle_cnt_nxt = '0;
                    end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                        timeout_err_nxt = 1'b1;
                        pkt_port_nxt    = sel_q;
                        pkt_beats_nxt   = beat_cnt;
                        rr_ptr_nxt      = sel_q;
                        beat_cnt_nxt    = '0;
                        idle_cnt_nxt    = '0;
                        state_nxt       = S_IDLE;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end else begin
                    idle_cnt_nxt = '0;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            sel_q         <= '0;
            rr_ptr        <= SEL_W'(N_PORT - 1);
            pkt_port_q    <= '0;
            pkt_beats_q   <= '0;
            beat_cnt      <= '0;
            idle_cnt      <= '0;
            pkt_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            sel_q         <= sel_nxt;
            rr_ptr        <= rr_ptr_nxt;
            pkt_port_q    <= pkt_port_nxt;
            pkt_beats_q   <= pkt_beats_nxt;
            beat_cnt      <= beat_cnt_nxt;
            idle_cnt      <= idle_cnt_nxt;
            pkt_done_q    <= pkt_done_nxt;
            timeout_err_q <= timeout_err_nxt;
        end
    end

    assign out_valid   = (state == S_LOCK) && sel_valid;
    assign sel         = sel_q;
    assign sel_en      = (state == S_LOCK);
    assign pkt_done    = pkt_done_q;
    assign pkt_port    = pkt_port_q;
    assign pkt_beats   = pkt_beats_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_nasti_stream_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_nasti_stream_rr_arbiter
//
// Directed bench for the stream arbiter (N_PORT=4, DEST_ID=0, TIMEOUT=4).
// Each test queues the packet completions it expects; an independent monitor
// pops one entry per pkt_done/timeout_err pulse and checks port, beat count,
// completion kind and the number of beats actually seen on the output.
// ----------------------------------------------------------------------------
module tb_nasti_stream_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 2;

    logic            aclk;
    logic            aresetn;
    logic [NP-1:0]   in_valid;
    logic [NP-1:0]   in_last;
    logic [NP*DW-1:0] in_dest;
    logic [NP-1:0]   in_ready;
    logic            out_ready;
    logic            out_valid;
    logic [1:0]      sel;
    logic            sel_en;
    logic            pkt_done;
    logic [1:0]      pkt_port;
    logic [15:0]     pkt_beats;
    logic            timeout_err;

    nasti_stream_rr_arbiter #(
        .N_PORT     (NP),
        .DEST_WIDTH (DW),
        .DEST_ID    (0),
        .TIMEOUT    (4),
        .BEAT_W     (16)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_dest     (in_dest),
        .in_ready    (in_ready),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .sel         (sel),
        .sel_en      (sel_en),
        .pkt_done    (pkt_done),
        .pkt_port    (pkt_port),
        .pkt_beats   (pkt_beats),
        .timeout_err (timeout_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int port;
        int beats;
        bit tmo;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad   = 0;

    // Source model: rem = beats left in the current packet, npk = packets
    // queued after it, plen = their length, gate = force t_valid low.
    int         rem[NP];
    int         npk[NP];
    int         plen[NP];
    logic [1:0] dest[NP];
    logic [NP-1:0] gate;
    logic [NP-1:0] fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_pkt(input int p, input int b, input bit t);
        exp_t e;
        e.port  = p;
        e.beats = b;
        e.tmo   = t;
        sbq.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            in_valid[i]           = gate[i] && (rem[i] > 0);
            in_last[i]            = (rem[i] == 1);
            in_dest[i*DW +: DW]   = dest[i];
        end
    endtask

    task automatic update();
        for (int i = 0; i < NP; i++) begin
            if (fire[i] && rem[i] > 0) rem[i]--;
            if (rem[i] == 0 && npk[i] > 0) begin
                rem[i] = plen[i];
                npk[i]--;
            end
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NP; i++) begin
            rem[i]  = 0;
            npk[i]  = 0;
            plen[i] = 1;
            dest[i] = 2'd0;
        end
        gate = '1;
    endtask

    // One clock: inputs change just after the rising edge, returns at the
    // falling edge with outputs settled.
    task automatic cyc(input logic ordy);
        @(posedge aclk);
        #1;
        update();
        out_ready = ordy;
        drive();
        @(negedge aclk);
    endtask

    task automatic reset_dut();
        aresetn   = 1'b0;
        clear_src();
        out_ready = 1'b0;
        drive();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
    endtask

    // Handshake capture for the source model.
    initial begin
        fire = '0;
        forever begin
            @(negedge aclk);
            fire = in_valid & in_ready;
        end
    end

    // Completion monitor / scoreboard.
    initial begin
        int   xfer;
        exp_t e;
        xfer = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                xfer = 0;
            end else begin
                if (out_valid && out_ready) xfer++;
                if (pkt_done || timeout_err) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_completion", {30'd0, pkt_done, timeout_err}, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_pkt_port",    pkt_port,    e.port);
                        chk("sb_pkt_beats",   pkt_beats,   e.beats);
                        chk("sb_timeout_err", timeout_err, e.tmo);
                        chk("sb_pkt_done",    pkt_done,    !e.tmo);
                        chk("sb_out_beats",   xfer,        e.beats);
                    end
                    xfer = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        aresetn   = 1'b0;
        out_ready = 1'b0;
        clear_src();
        drive();

        // 1. reset hold with all ports valid, then port 0 first
        for (int i = 0; i < NP; i++) rem[i] = 1;
        out_ready = 1'b1;
        drive();
        repeat (2) @(negedge aclk);
        chk("t1_rst_in_ready",  in_ready,  0);
        chk("t1_rst_out_valid", out_valid, 0);
        chk("t1_rst_sel_en",    sel_en,    0);
        chk("t1_rst_sel",       sel,       0);
        chk("t1_rst_pulses",    {pkt_done, timeout_err}, 0);
        chk("t1_rst_pkt_beats", pkt_beats, 0);
        expect_pkt(0, 1, 0);
        expect_pkt(1, 1, 0);
        expect_pkt(2, 1, 0);
        expect_pkt(3, 1, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("t1_sel_en_before_edge", sel_en, 0);
        cyc(1'b1);
        chk("t1_grant_sel_en",    sel_en,    1);
        chk("t1_grant_sel",       sel,       0);
        chk("t1_grant_out_valid", out_valid, 1);
        repeat (12) cyc(1'b1);
        chk("t1_sb_empty", sbq.size(), 0);

        // 2. round robin over ports 0,2,3 with 2-beat packets
        reset_dut();
        foreach (rem[i]) begin
            if (i != 1) begin
                rem[i]  = 2;
                npk[i]  = 1;
                plen[i] = 2;
            end
        end
        out_ready = 1'b1;
        drive();
        expect_pkt(0, 2, 0);
        expect_pkt(2, 2, 0);
        expect_pkt(3, 2, 0);
        expect_pkt(0, 2, 0);
        expect_pkt(2, 2, 0);
        expect_pkt(3, 2, 0);
        begin
            int  j  = 0;
            int  nd = 0;
            bit  started = 0;
            for (int c = 0; c < 80 && nd < 6; c++) begin
                cyc(1'b1);
                if (!started && sel_en) begin
                    started = 1;
                    j = 0;
                end else if (started) begin
                    j++;
                end
                if (pkt_done) nd++;
            end
            chk("t2_done_count", nd, 6);
            chk("t2_span_cycles", j, 17);
        end
        repeat (4) cyc(1'b1);
        chk("t2_sb_empty", sbq.size(), 0);

        // 3. destination filter
        reset_dut();
        dest[1] = 2'd1;
        rem[1]  = 50;
        rem[2]  = 1;
        npk[2]  = 1;
        plen[2] = 1;
        out_ready = 1'b1;
        drive();
        expect_pkt(2, 1, 0);
        expect_pkt(2, 1, 0);
        for (int c = 0; c < 12; c++) begin
            cyc(1'b1);
            chk("t3_in_ready1", in_ready[1], 0);
            if (sel_en) chk("t3_sel", sel, 2);
        end
        chk("t3_sb_empty", sbq.size(), 0);

        // 4. backpressure on a 3-beat packet
        reset_dut();
        rem[1] = 3;
        drive();
        expect_pkt(1, 3, 0);
        begin
            logic [4:0] pat;
            pat = 5'b11001;
            for (int c = 0; c < 5; c++) begin
                cyc(pat[c]);
                chk("t4_in_ready", in_ready, pat[c] ? 4'b0010 : 4'b0000);
                chk("t4_out_valid", out_valid, 1);
            end
        end
        repeat (3) cyc(1'b1);
        chk("t4_sb_empty", sbq.size(), 0);

        // 5. idle timeout, then port 0 wins over port 3
        reset_dut();
        rem[3] = 5;
        drive();
        expect_pkt(3, 1, 1);
        expect_pkt(0, 1, 0);
        expect_pkt(3, 1, 0);
        cyc(1'b1);
        chk("t5_lock_port3", sel, 3);
        gate[3] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1);
            chk("t5_timeout_err", timeout_err, (j == 4));
            chk("t5_sel_en", sel_en, (j < 4));
            if (j == 3) begin
                rem[0]  = 1;
                rem[3]  = 1;
                gate[3] = 1'b1;
            end
        end
        cyc(1'b1);
        chk("t5_regrant_en",  sel_en, 1);
        chk("t5_regrant_sel", sel,    0);
        repeat (8) cyc(1'b1);
        chk("t5_sb_empty", sbq.size(), 0);

        // 6. asynchronous reset in the middle of a packet
        reset_dut();
        rem[2] = 5;
        drive();
        cyc(1'b1);
        cyc(1'b1);
        chk("t6_mid_out_valid", out_valid, 1);
        #3;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_in_ready",  in_ready,  0);
        chk("t6_rst_sel_en",    sel_en,    0);
        clear_src();
        drive();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        rem[0] = 1;
        rem[2] = 1;
        out_ready = 1'b1;
        drive();
        expect_pkt(0, 1, 0);
        expect_pkt(2, 1, 0);
        cyc(1'b1);
        chk("t6_after_rst_sel", {sel_en, sel}, 3'b100);
        repeat (8) cyc(1'b1);
        chk("t6_sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
